data_mem_responder: RTL

//  Responder end of the CPU data-memory interface: receives load/store requests from the

---
 rtl/data_mem_responder.sv | 70 +++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM responder with byte-enable stores and programmable wait states.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic l_we;
  logic [31:0] l_addr, l_wdata;
  logic [3:0] l_be;
  logic [31:0] mem [DEPTH_WORDS];
  logic accept, a_we, bad;
  logic [31:0] a_addr, off;
  logic [IDX_W-1:0] idx;
  // With no wait states RESP is entered on the accept edge itself, so check the live request there.
  always_comb begin
    accept = state == IDLE && req;
    a_we = state == IDLE ? we : l_we;
    a_addr = state == IDLE ? addr : l_addr;
    off = a_addr - BASE_ADDR;
    bad = |a_addr[1:0] || off >= 32'(DEPTH_WORDS * 4);
    idx = off[IDX_W+1:2];
    next = state == IDLE ? (req ? (WAIT_CYCLES > 0 ? WAIT : RESP) : IDLE) :
           state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
  end
  assign busy = state != IDLE;
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      ready <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
      l_we <= 1'b0;
      l_addr <= '0;
      l_wdata <= '0;
      l_be <= '0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      state <= next;
      ready <= next == RESP;
      err <= next == RESP && bad;
      rdata <= (next == RESP && !bad && !a_we) ? mem[idx] : '0;
      if (accept) begin
        l_we <= we;
        l_addr <= addr;
        l_wdata <= wdata;
        l_be <= be;
        cnt <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (state == RESP && l_we && !bad)
        for (int i = 0; i < 4; i++) if (l_be[i]) mem[idx][8*i+:8] <= l_wdata[8*i+:8];
    end
  end
endmodule
